// File: rtl/nf_ram_arb.sv
// Round-robin arbiter sharing one single-port nf_ram between two masters.
// Byte-enable writes merge with the combinational read word in the same cycle.
module nf_ram_arb #(
    parameter int depth = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic        m0_we,
    input  logic [3:0]  m0_be,
    input  logic [31:0] m0_wd,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rd,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic        m1_we,
    input  logic [3:0]  m1_be,
    input  logic [31:0] m1_wd,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rd,
    output logic        m1_err,
    output logic [31:0] ram_addr,
    output logic        ram_we,
    output logic [31:0] ram_wd,
    input  logic [31:0] ram_rd
);

    logic        r_last;
    logic        r_m0_rvalid;
    logic [31:0] r_m0_rd;
    logic        r_m0_err;
    logic        r_m1_rvalid;
    logic [31:0] r_m1_rd;
    logic        r_m1_err;

    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_any;
    logic [31:0] w_addr;
    logic        w_we;
    logic [3:0]  w_be;
    logic [31:0] w_wd;
    logic [29:0] w_idx;
    logic        w_inr;
    logic [31:0] w_rsp;
    logic        w_unused;

    // On a tie the master that was not granted last wins
    assign w_gnt0 = !rst && m0_req && (!m1_req || r_last);
    assign w_gnt1 = !rst && m1_req && (!m0_req || !r_last);
    assign w_any  = w_gnt0 || w_gnt1;

    assign w_addr = w_gnt1 ? m1_addr : m0_addr;
    assign w_we   = w_gnt1 ? m1_we   : m0_we;
    assign w_be   = w_gnt1 ? m1_be   : m0_be;
    assign w_wd   = w_gnt1 ? m1_wd   : m0_wd;

    assign w_idx    = w_addr[31:2];
    assign w_unused = &{1'b0, w_addr[1:0]};
    assign w_inr    = {2'b00, w_idx} < 32'(depth);

    assign ram_addr = w_any ? {2'b00, w_idx} : 32'h0;
    assign ram_we   = w_any && w_we && (|w_be) && w_inr;
    assign w_rsp    = w_inr ? ram_rd : 32'h0;

    always_comb begin
        ram_wd = ram_rd;
        for (int i = 0; i < 4; i++) begin
            if (w_be[i]) ram_wd[8*i +: 8] = w_wd[8*i +: 8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last      <= 1'b1;
            r_m0_rvalid <= 1'b0;
            r_m0_rd     <= 32'h0;
            r_m0_err    <= 1'b0;
            r_m1_rvalid <= 1'b0;
            r_m1_rd     <= 32'h0;
            r_m1_err    <= 1'b0;
        end else begin
            r_m0_rvalid <= w_gnt0;
            r_m1_rvalid <= w_gnt1;
            if (w_gnt0) begin
                r_m0_rd  <= w_rsp;
                r_m0_err <= !w_inr;
                r_last   <= 1'b0;
            end
            if (w_gnt1) begin
                r_m1_rd  <= w_rsp;
                r_m1_err <= !w_inr;
                r_last   <= 1'b1;
            end
        end
    end

    assign m0_gnt    = w_gnt0;
    assign m1_gnt    = w_gnt1;
    assign m0_rvalid = r_m0_rvalid;
    assign m0_rd     = r_m0_rd;
    assign m0_err    = r_m0_err;
    assign m1_rvalid = r_m1_rvalid;
    assign m1_rd     = r_m1_rd;
    assign m1_err    = r_m1_err;

endmodule

// File: tb/tb_nf_ram_arb.sv
// Bench for nf_ram_arb: attached RAM model plus a word-level reference
// of arbitration and memory contents, driven by directed and random traffic.
module tb_nf_ram_arb;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
    logic [31:0] m0_addr = 0, m0_wd = 0, m1_addr = 0, m1_wd = 0;
    logic [3:0]  m0_be = 0, m1_be = 0;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rd, m1_rd;
    logic [31:0] ram_addr, ram_wd, ram_rd;
    logic        ram_we;

    logic [31:0] ram_mem [DEPTH];
    logic [31:0] init_val [DEPTH];
    logic        init_req = 1'b0;

    logic [31:0] mem_m [DEPTH];
    bit          m_last;
    logic [31:0] exp_rd [2];
    logic        exp_err [2];

    int n_chk = 0;
    int n_pass = 0;

    nf_ram_arb #(.depth(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_be(m0_be),
        .m0_wd(m0_wd), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
        .m0_rd(m0_rd), .m0_err(m0_err),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_be(m1_be),
        .m1_wd(m1_wd), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
        .m1_rd(m1_rd), .m1_err(m1_err),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wd(ram_wd), .ram_rd(ram_rd)
    );

    always #5 clk = ~clk;

    assign ram_rd = (ram_addr < DEPTH) ? ram_mem[ram_addr[5:0]] : 32'h0;

    always @(posedge clk) begin
        if (init_req) begin
            for (int i = 0; i < DEPTH; i++) ram_mem[i] <= init_val[i];
        end else if (ram_we && ram_addr < DEPTH) begin
            ram_mem[ram_addr[5:0]] <= ram_wd;
        end
    end

    // Reference: who gets the bus given the two request lines
    function automatic int pick(bit r0, bit r1);
        if (r0 && !r1) return 0;
        if (r1 && !r0) return 1;
        if (r0 && r1) return m_last ? 0 : 1;
        return -1;
    endfunction

    task automatic model_access(input logic [31:0] a, input logic w,
                                input logic [3:0] b, input logic [31:0] d,
                                output logic [31:0] rsp, output logic e,
                                output logic wen);
        int idx;
        idx = int'(a >> 2);
        if (idx >= DEPTH) begin
            rsp = 32'h0; e = 1'b1; wen = 1'b0;
        end else begin
            rsp = mem_m[idx]; e = 1'b0; wen = w && (b != 4'h0);
            if (wen)
                for (int i = 0; i < 4; i++)
                    if (b[i]) mem_m[idx][8*i +: 8] = d[8*i +: 8];
        end
    endtask

    task automatic predict(output int g, output logic [31:0] rsp,
                           output logic e, output logic wen);
        g = pick(m0_req, m1_req);
        rsp = 32'h0; e = 1'b0; wen = 1'b0;
        if (g == 0) model_access(m0_addr, m0_we, m0_be, m0_wd, rsp, e, wen);
        if (g == 1) model_access(m1_addr, m1_we, m1_be, m1_wd, rsp, e, wen);
        if (g >= 0) begin
            m_last = (g == 1);
            exp_rd[g] = rsp;
            exp_err[g] = e;
        end
    endtask

    task automatic model_reset();
        m_last = 1'b1;
        exp_rd[0] = 0; exp_rd[1] = 0;
        exp_err[0] = 0; exp_err[1] = 0;
    endtask

    task automatic drive0(input bit r, input logic [31:0] a, input bit w,
                          input logic [3:0] b, input logic [31:0] d);
        m0_req = r; m0_addr = a; m0_we = w; m0_be = b; m0_wd = d;
    endtask

    task automatic drive1(input bit r, input logic [31:0] a, input bit w,
                          input logic [3:0] b, input logic [31:0] d);
        m1_req = r; m1_addr = a; m1_we = w; m1_be = b; m1_wd = d;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        #1 rst = 1'b1;
        drive0(1, 32'h8, 1, 4'hF, 32'h1);
        drive1(1, 32'h4, 0, 4'h0, 32'h0);
        #2;
        n_chk++;
        if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0)
            $display("FAIL rst_gnt: got %b%b expected 00", m0_gnt, m1_gnt);
        else n_pass++;
        n_chk++;
        if (ram_we !== 1'b0 || ram_addr !== 32'h0)
            $display("FAIL rst_ram: got we=%b addr=%h expected 0/0", ram_we, ram_addr);
        else n_pass++;
        drive0(0, 0, 0, 0, 0);
        drive1(0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            v = $urandom;
            init_val[i] = v;
            mem_m[i] = v;
        end
        init_req = 1'b1;
        @(posedge clk); #1 init_req = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        model_reset();
        #2;
        n_chk++;
        if (m0_rvalid !== 0 || m0_rd !== 0 || m0_err !== 0)
            $display("FAIL rst_m0_rsp: got v=%b rd=%h e=%b expected 0", m0_rvalid, m0_rd, m0_err);
        else n_pass++;
        n_chk++;
        if (m1_rvalid !== 0 || m1_rd !== 0 || m1_err !== 0)
            $display("FAIL rst_m1_rsp: got v=%b rd=%h e=%b expected 0", m1_rvalid, m1_rd, m1_err);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        int g; logic [31:0] rsp; logic e, wen;
        drive0(1, 32'h8, 1, 4'hF, 32'hDEADBEEF);
        #3 predict(g, rsp, e, wen);
        n_chk++;
        if (m0_gnt !== 1'b1 || ram_we !== wen)
            $display("FAIL wr_gnt: got gnt=%b we=%b expected 1/%b", m0_gnt, ram_we, wen);
        else n_pass++;
        @(posedge clk); #1;
        n_chk++;
        if (m0_rvalid !== 1'b1 || m0_rd !== rsp || m0_err !== e)
            $display("FAIL wr_rsp: got v=%b rd=%h expected 1/%h", m0_rvalid, m0_rd, rsp);
        else n_pass++;
        drive0(1, 32'h8, 0, 4'h0, 32'h0);
        #3 predict(g, rsp, e, wen);
        n_chk++;
        if (m0_gnt !== 1'b1 || ram_we !== 1'b0)
            $display("FAIL rd_gnt: got gnt=%b we=%b expected 1/0", m0_gnt, ram_we);
        else n_pass++;
        @(posedge clk); #1;
        n_chk++;
        if (m0_rvalid !== 1'b1 || m0_rd !== 32'hDEADBEEF || m0_err !== 1'b0)
            $display("FAIL rd_rsp: got v=%b rd=%h e=%b expected 1/deadbeef/0", m0_rvalid, m0_rd, m0_err);
        else n_pass++;
        drive0(0, 0, 0, 0, 0);
    endtask

    task automatic test_byte_merge();
        int g; logic [31:0] rsp; logic e, wen;
        drive1(1, 32'h8, 1, 4'b0101, 32'h11223344);
        #3 predict(g, rsp, e, wen);
        n_chk++;
        if (m1_gnt !== 1'b1 || ram_we !== 1'b1)
            $display("FAIL bm_gnt: got gnt=%b we=%b expected 1/1", m1_gnt, ram_we);
        else n_pass++;
        @(posedge clk); #1;
        n_chk++;
        if (m1_rvalid !== 1'b1 || m1_rd !== 32'hDEADBEEF || m1_rd !== rsp)
            $display("FAIL bm_wr_rsp: got v=%b rd=%h expected 1/deadbeef", m1_rvalid, m1_rd);
        else n_pass++;
        drive1(1, 32'h8, 0, 4'h0, 32'h0);
        #3 predict(g, rsp, e, wen);
        @(posedge clk); #1;
        n_chk++;
        if (m1_rvalid !== 1'b1 || m1_rd !== 32'hDE22BE44 || m1_rd !== rsp)
            $display("FAIL bm_rd_rsp: got v=%b rd=%h expected 1/de22be44", m1_rvalid, m1_rd);
        else n_pass++;
        drive1(0, 0, 0, 0, 0);
    endtask

    task automatic test_out_of_range();
        int g; logic [31:0] rsp; logic e, wen;
        drive0(1, 32'h100, 1, 4'hF, $urandom);
        #3 predict(g, rsp, e, wen);
        n_chk++;
        if (m0_gnt !== 1'b1 || ram_we !== 1'b0 || ram_we !== wen)
            $display("FAIL oor_we: got gnt=%b we=%b expected 1/0", m0_gnt, ram_we);
        else n_pass++;
        @(posedge clk); #1;
        n_chk++;
        if (m0_rvalid !== 1'b1 || m0_err !== 1'b1 || m0_rd !== 32'h0)
            $display("FAIL oor_rsp: got v=%b e=%b rd=%h expected 1/1/0", m0_rvalid, m0_err, m0_rd);
        else n_pass++;
        drive0(1, 32'h0, 0, 4'h0, 32'h0);
        #3 predict(g, rsp, e, wen);
        @(posedge clk); #1;
        n_chk++;
        if (m0_rd !== rsp || m0_err !== 1'b0)
            $display("FAIL oor_word0: got rd=%h e=%b expected %h/0", m0_rd, m0_err, rsp);
        else n_pass++;
        drive0(0, 0, 0, 0, 0);
    endtask

    task automatic test_stream();
        int g; logic [31:0] rsp; logic e, wen;
        for (int k = 0; k < 4; k++) begin
            drive1(1, 32'(k * 4), 0, 4'h0, 32'h0);
            #3 predict(g, rsp, e, wen);
            n_chk++;
            if (m1_gnt !== 1'b1 || ram_addr !== 32'(k))
                $display("FAIL stream_gnt%0d: got gnt=%b addr=%h expected 1/%h", k, m1_gnt, ram_addr, k);
            else n_pass++;
            @(posedge clk); #1;
            n_chk++;
            if (m1_rvalid !== 1'b1 || m1_rd !== rsp)
                $display("FAIL stream_rsp%0d: got v=%b rd=%h expected 1/%h", k, m1_rvalid, m1_rd, rsp);
            else n_pass++;
        end
        drive1(0, 0, 0, 0, 0);
        #3;
        n_chk++;
        if (m1_gnt !== 1'b0 || ram_addr !== 32'h0)
            $display("FAIL stream_idle: got gnt=%b addr=%h expected 0/0", m1_gnt, ram_addr);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_contention();
        int g; logic [31:0] rsp; logic e, wen;
        rst = 1'b1;
        model_reset();
        @(posedge clk); #1 rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            drive0(1, 32'($urandom_range(0, DEPTH - 1) * 4), 0, 4'h0, 32'h0);
            drive1(1, 32'($urandom_range(0, DEPTH - 1) * 4), 0, 4'h0, 32'h0);
            #3 predict(g, rsp, e, wen);
            n_chk++;
            if (g != k % 2 || m0_gnt !== (k % 2 == 0) || m1_gnt !== (k % 2 == 1))
                $display("FAIL cont_gnt%0d: got %b%b expected m%0d", k, m0_gnt, m1_gnt, k % 2);
            else n_pass++;
            @(posedge clk); #1;
            n_chk++;
            if (m0_rvalid !== (g == 0) || m1_rvalid !== (g == 1) ||
                (g == 0 && m0_rd !== rsp) || (g == 1 && m1_rd !== rsp))
                $display("FAIL cont_rsp%0d: got v=%b%b rd=%h/%h expected m%0d %h",
                         k, m0_rvalid, m1_rvalid, m0_rd, m1_rd, g, rsp);
            else n_pass++;
        end
        drive0(0, 0, 0, 0, 0);
        drive1(0, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        int g; logic [31:0] rsp; logic e, wen;
        bit act [2];
        logic [31:0] pa [2];
        logic [31:0] pd [2];
        bit pw [2];
        logic [3:0] pb [2];
        logic [31:0] exp_ra;
        act[0] = 0; act[1] = 0;
        for (int c = 0; c < 200; c++) begin
            for (int m = 0; m < 2; m++) begin
                if (!act[m] && $urandom_range(0, 9) < 7) begin
                    act[m] = 1;
                    pa[m] = 32'(($urandom_range(0, 71) << 2) | $urandom_range(0, 3));
                    pw[m] = $urandom_range(0, 1);
                    pb[m] = 4'($urandom_range(0, 15));
                    pd[m] = $urandom;
                end
            end
            drive0(act[0], pa[0], pw[0], pb[0], pd[0]);
            drive1(act[1], pa[1], pw[1], pb[1], pd[1]);
            #3;
            exp_ra = 32'h0;
            g = pick(act[0], act[1]);
            if (g >= 0) exp_ra = pa[g] >> 2;
            predict(g, rsp, e, wen);
            n_chk++;
            if (m0_gnt !== (g == 0) || m1_gnt !== (g == 1))
                $display("FAIL rnd_gnt c%0d: got %b%b expected m%0d", c, m0_gnt, m1_gnt, g);
            else n_pass++;
            n_chk++;
            if (ram_we !== wen || ram_addr !== exp_ra)
                $display("FAIL rnd_ram c%0d: got we=%b addr=%h expected %b/%h", c, ram_we, ram_addr, wen, exp_ra);
            else n_pass++;
            if (g >= 0) act[g] = 0;
            @(posedge clk); #1;
            n_chk++;
            if (m0_rvalid !== (g == 0) || m0_rd !== exp_rd[0] || m0_err !== exp_err[0])
                $display("FAIL rnd_m0 c%0d: got v=%b rd=%h e=%b expected %b/%h/%b",
                         c, m0_rvalid, m0_rd, m0_err, g == 0, exp_rd[0], exp_err[0]);
            else n_pass++;
            n_chk++;
            if (m1_rvalid !== (g == 1) || m1_rd !== exp_rd[1] || m1_err !== exp_err[1])
                $display("FAIL rnd_m1 c%0d: got v=%b rd=%h e=%b expected %b/%h/%b",
                         c, m1_rvalid, m1_rd, m1_err, g == 1, exp_rd[1], exp_err[1]);
            else n_pass++;
        end
        drive0(0, 0, 0, 0, 0);
        drive1(0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_mid();
        int g; logic [31:0] rsp; logic e, wen;
        drive0(1, 32'h14, 0, 4'h0, 32'h0);
        #3 predict(g, rsp, e, wen);
        @(posedge clk); #1;
        drive0(1, 32'h14, 1, 4'hF, ~mem_m[5]);
        #1 rst = 1'b1;
        #1;
        n_chk++;
        if (m0_gnt !== 1'b0 || ram_we !== 1'b0 || ram_addr !== 32'h0)
            $display("FAIL mid_rst_comb: got gnt=%b we=%b addr=%h expected 0/0/0", m0_gnt, ram_we, ram_addr);
        else n_pass++;
        n_chk++;
        if (m0_rvalid !== 1'b0 || m0_rd !== 32'h0)
            $display("FAIL mid_rst_rsp: got v=%b rd=%h expected 0/0", m0_rvalid, m0_rd);
        else n_pass++;
        model_reset();
        @(posedge clk); #1;
        drive0(0, 0, 0, 0, 0);
        @(posedge clk); #1 rst = 1'b0;
        drive0(1, 32'h14, 0, 4'h0, 32'h0);
        drive1(1, 32'h14, 0, 4'h0, 32'h0);
        #3 predict(g, rsp, e, wen);
        n_chk++;
        if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0)
            $display("FAIL mid_tie: got %b%b expected 10", m0_gnt, m1_gnt);
        else n_pass++;
        @(posedge clk); #1;
        n_chk++;
        if (m0_rvalid !== 1'b1 || m0_rd !== rsp)
            $display("FAIL mid_nowrite: got v=%b rd=%h expected 1/%h", m0_rvalid, m0_rd, rsp);
        else n_pass++;
        drive0(0, 0, 0, 0, 0);
        drive1(0, 0, 0, 0, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_merge();
        test_out_of_range();
        test_stream();
        test_contention();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/nf_ram_arb.md
# nf_ram_arb

Two-master arbiter that shares a single-port `nf_ram` instance (combinational read, synchronous full-word write) between two requesters, for example instruction fetch and load/store. It grants at most one access per cycle with round-robin fairness and performs byte-enable writes as a same-cycle read-merge-write. It returns registered read data with a one-cycle-later valid strobe, and flags out-of-range addresses.

## Interface
Parameters:
- `depth`, 64, RAM size in 32-bit words; must match the attached `nf_ram`.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `m0_req`  in  1  master 0 access request; held with stable address/data until granted.
- `m0_addr`  in  32  master 0 byte address; bits [1:0] ignored.
- `m0_we`  in  1  master 0 write (1) / read (0).
- `m0_be`  in  4  master 0 byte enables; bit i covers wd[8i+7:8i].
- `m0_wd`  in  32  master 0 write data.
- `m0_gnt`  out  1  master 0 access performed this cycle (combinational).
- `m0_rvalid`  out  1  master 0 response strobe, one cycle.
- `m0_rd`  out  32  master 0 response data (registered).
- `m0_err`  out  1  master 0 out-of-range flag, valid with `m0_rvalid`.
- `m1_*`  same set and meaning for master 1.
- `ram_addr`  out  32  word index to `nf_ram`.
- `ram_we`  out  1  RAM write enable.
- `ram_wd`  out  32  merged write word.
- `ram_rd`  in  32  RAM combinational read data.

## Operation
- State: priority pointer `last` (1 bit: master granted most recently), plus a response register per master (`rvalid`, `rd`, `err`).
- Arbitration, each cycle:
  - Only one `req` high: that master is granted.
  - Both high: the master other than `last` is granted.
  - `last` updates to the granted master on the clock edge; it is unchanged when nothing is granted.
- Exactly one of `m0_gnt`/`m1_gnt` is high when any request is high. A request is never starved for more than 1 cycle.
- Word index is `addr[31:2]`. `ram_addr` = word index of the granted master, zero when idle.
- In range: word index < `depth`. Out of range: no RAM write, response `rd` = 0, `err` = 1.
- Read access: `ram_we` = 0. `ram_rd` is captured into the granted master's `rd`.
- Write access: `ram_wd[8i+7:8i]` = `be[i]` ? `wd` byte : `ram_rd` byte.
  - `ram_we` = `we & |be & in_range`.
  - Response `rd` = word contents before the write; the write is acknowledged via `rvalid`.
  - `be` = 0 behaves as a read.
- Non-granted master: its `rvalid` is 0 next cycle and its `rd`/`err` hold their previous values.
- Reset (asynchronous, any time, including mid-access):
  - All `rvalid`, `err` = 0; all `rd` = 0; `last` = 1, so master 0 wins the first tie.
  - `m*_gnt`, `ram_we` forced 0 and `ram_addr` = 0 while `rst` is high.
  - An access whose edge coincides with reset assertion is lost (no write, no response).

## Timing
- Cycle N: `req` high and `gnt` high; the RAM address and data are driven combinationally. The write commits at the rising edge ending cycle N.
- Cycle N+1: `rvalid` high for exactly one cycle; `rd`/`err` valid and held until the next response.
- Latency from grant to response is 1 cycle. Throughput is 1 access/cycle total.
- A single active master may be granted every cycle. Its responses are back-to-back, and `rvalid` stays high continuously.
- Both masters requesting continuously: grants alternate every cycle.
- The master may change `addr`/`we`/`wd`/`be` or drop `req` in the cycle after `gnt`. It must not change them before `gnt`.
- Read-after-write to the same word by either master in cycle N+1 returns the new data, because RAM read is combinational after the edge.

## Test plan
- Reset, then m0 writes `addr=0x8`, `be=4'hF`, `wd=0xDEADBEEF`. Then m0 reads `0x8`. Required: `m0_gnt` on both cycles, second `m0_rvalid` with `m0_rd=0xDEADBEEF`, `err`=0.
- Byte merge: word 2 = `0xDEADBEEF`, m1 writes `be=4'b0101`, `wd=0x11223344`, then reads. Required: the write response returns `0xDEADBEEF` and the read returns `0xDE22BE44`.
- Contention: both masters request reads every cycle for 6 cycles after reset. Required grant order is m0, m1, m0, m1, m0, m1, with each master's `rvalid` on alternate cycles.
- Out of range with `depth=64`: m0 writes `addr=0x100` (word 64). Required: `ram_we`=0, `m0_rvalid`=1 with `m0_err`=1 and `m0_rd`=0, and word 0 unchanged.
- Single requester streaming: m1 reads words 0..3 on consecutive cycles. Required: `m1_gnt` high for 4 cycles and `m1_rvalid` high for 4 consecutive cycles, one later, with data in order.
- Reset mid-stream: assert `rst` asynchronously during a granted m0 write. Required: `gnt`, `ram_we` and `rvalid` drop immediately, and after release the first tie is granted to m0.
